// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared FSM states, master ids and response codes for the AXI-lite arbiter
package axi_arb_pkg;
   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} arb_state_e;
   localparam logic MST_IFU = 1'b0;
   localparam logic MST_LSU = 1'b1;
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin picker with a priority register updated on a strobe
module rr_arb2 import axi_arb_pkg::*; #(
   parameter bit RESET_PRIO = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic upd,
   input  logic upd_prio,
   output logic grant
);
   logic prio;
   // favoured master; reloaded whenever a transaction retires
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) prio <= RESET_PRIO;
      else if (upd) prio <= upd_prio;
   // a lone requester wins outright, contention goes to the favoured master
   always_comb grant = (req0 && req1) ? prio : (req1 ? MST_LSU : MST_IFU);
endmodule

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: shares one AXI-lite slave between the IFU (read-only) and the LSU, one transaction at a time
module axi_lite_arbiter import axi_arb_pkg::*; #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter bit RESET_PRIO = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   m0_araddr,
   input  logic                m0_arvalid,
   output logic                m0_arready,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   input  logic [ADDR_W-1:0]   m1_araddr,
   input  logic                m1_arvalid,
   output logic                m1_arready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   output logic [1:0]          m1_bresp,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   output logic [ADDR_W-1:0]   s_araddr,
   output logic                s_arvalid,
   input  logic                s_arready,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic                s_rvalid,
   output logic                s_rready,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wvalid,
   input  logic                s_wready,
   input  logic [1:0]          s_bresp,
   input  logic                s_bvalid,
   output logic                s_bready
);
   arb_state_e state, state_nxt;
   logic owner, owner_nxt, aw_done, aw_done_nxt, w_done, w_done_nxt;
   logic req0, req1, m1_rd, grant;
   logic rd_a, rd_d, wr_a, wr_r, own0, own1;
   logic ar_hs, r_hs, aw_hs, w_hs, b_hs, wr_both;

   assign req0  = m0_arvalid;
   assign m1_rd = m1_arvalid;
   assign req1  = m1_rd | m1_awvalid | m1_wvalid;

   assign rd_a = state == RD_ADDR;
   assign rd_d = state == RD_DATA;
   assign wr_a = state == WR_ADDR;
   assign wr_r = state == WR_RESP;
   assign own0 = owner == MST_IFU;
   assign own1 = owner == MST_LSU;

   assign s_araddr   = rd_a ? (own1 ? m1_araddr : m0_araddr) : '0;
   assign s_arvalid  = rd_a && (own1 ? m1_arvalid : m0_arvalid);
   assign m0_arready = rd_a && own0 && s_arready;
   assign m1_arready = rd_a && own1 && s_arready;

   assign s_rready   = rd_d && (own1 ? m1_rready : m0_rready);
   assign m0_rvalid  = rd_d && own0 && s_rvalid;
   assign m0_rdata   = (rd_d && own0) ? s_rdata : '0;
   assign m0_rresp   = (rd_d && own0) ? s_rresp : AXI_RESP_OKAY;
   assign m1_rvalid  = rd_d && own1 && s_rvalid;
   assign m1_rdata   = (rd_d && own1) ? s_rdata : '0;
   assign m1_rresp   = (rd_d && own1) ? s_rresp : AXI_RESP_OKAY;

   // AW and W progress independently; a finished channel has its valid masked
   assign s_awaddr   = wr_a ? m1_awaddr : '0;
   assign s_awvalid  = wr_a && !aw_done && m1_awvalid;
   assign m1_awready = wr_a && !aw_done && s_awready;
   assign s_wdata    = wr_a ? m1_wdata : '0;
   assign s_wstrb    = wr_a ? m1_wstrb : '0;
   assign s_wvalid   = wr_a && !w_done && m1_wvalid;
   assign m1_wready  = wr_a && !w_done && s_wready;

   assign s_bready   = wr_r && m1_bready;
   assign m1_bvalid  = wr_r && s_bvalid;
   assign m1_bresp   = wr_r ? s_bresp : AXI_RESP_OKAY;

   assign ar_hs   = s_arvalid && s_arready;
   assign r_hs    = s_rvalid && s_rready;
   assign aw_hs   = s_awvalid && s_awready;
   assign w_hs    = s_wvalid && s_wready;
   assign b_hs    = s_bvalid && s_bready;
   assign wr_both = (aw_done || aw_hs) && (w_done || w_hs);

   rr_arb2 #(.RESET_PRIO(RESET_PRIO)) u_rr (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0),
      .req1     (req1),
      .upd      (r_hs || b_hs),
      .upd_prio (~owner),
      .grant    (grant)
   );

   // transaction sequencing: grant in IDLE, hold until the R or B handshake
   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      aw_done_nxt = aw_done;
      w_done_nxt  = w_done;
      case (state)
         IDLE:
            if (req0 || req1) begin
               owner_nxt = grant;
               state_nxt = (grant == MST_LSU && !m1_rd) ? WR_ADDR : RD_ADDR;
            end
         RD_ADDR: state_nxt = ar_hs ? RD_DATA : RD_ADDR;
         RD_DATA: state_nxt = r_hs ? IDLE : RD_DATA;
         WR_ADDR: begin
            aw_done_nxt = wr_both ? 1'b0 : (aw_done || aw_hs);
            w_done_nxt  = wr_both ? 1'b0 : (w_done || w_hs);
            state_nxt   = wr_both ? WR_RESP : WR_ADDR;
         end
         WR_RESP: state_nxt = b_hs ? IDLE : WR_RESP;
         default: state_nxt = IDLE;
      endcase
   end

   // state, owner and write-progress flags
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         owner   <= MST_IFU;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state   <= state_nxt;
         owner   <= owner_nxt;
         aw_done <= aw_done_nxt;
         w_done  <= w_done_nxt;
      end

   // a granted master must hold each valid until the slave accepts it
   a_ar_hold: assert property (@(posedge clk) disable iff (!rst_n) s_arvalid && !s_arready |=> s_arvalid);
   a_aw_hold: assert property (@(posedge clk) disable iff (!rst_n) s_awvalid && !s_awready |=> s_awvalid);
   a_w_hold:  assert property (@(posedge clk) disable iff (!rst_n) s_wvalid && !s_wready |=> s_wvalid);
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: scoreboard bench with an SRAM slave model behind the arbiter
module tb_axi_lite_arbiter;
   import axi_arb_pkg::*;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] m0_araddr = '0, m1_araddr = '0, m1_awaddr = '0, m1_wdata = '0;
   logic        m0_arvalid = 1'b0, m1_arvalid = 1'b0, m1_awvalid = 1'b0, m1_wvalid = 1'b0;
   logic        m0_rready = 1'b1, m1_rready = 1'b1, m1_bready = 1'b1;
   logic [3:0]  m1_wstrb = '0;
   logic        m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
   logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
   logic        s_wvalid, s_wready, s_bvalid, s_bready;
   logic [1:0]  s_rresp, s_bresp;

   axi_lite_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
      .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
   );

   int errors = 0, checks = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] init_val(input int i);
      return (i == 0) ? 32'h0000_0413 : {16'hC0DE, 8'h00, i[7:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] st);
      for (int i = 0; i < 4; i++) if (st[i]) old[i*8 +: 8] = d[i*8 +: 8];
      return old;
   endfunction

   // SRAM slave model: 1 KB, reads answer after rd_wait idle cycles
   logic [31:0] mem [0:255];
   logic [31:0] ref_mem [0:255];
   int          rd_wait = 1;
   int          rcnt;
   logic        rbusy, aw_got, w_got;
   logic [31:0] raddr, waddr, wd;
   logic [3:0]  ws;
   assign s_arready = !rbusy;
   assign s_awready = !aw_got && !s_bvalid;
   assign s_wready  = !w_got && !s_bvalid;
   assign s_rresp   = 2'b00;
   assign s_bresp   = 2'b00;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rbusy <= 1'b0; s_rvalid <= 1'b0; s_rdata <= '0; rcnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b0;
         raddr <= '0; waddr <= '0; wd <= '0; ws <= '0;
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      end else begin
         if (s_arvalid && s_arready) begin
            raddr <= s_araddr; rbusy <= 1'b1; rcnt <= rd_wait;
         end else if (rbusy && !s_rvalid) begin
            if (rcnt == 0) begin s_rvalid <= 1'b1; s_rdata <= mem[raddr[9:2]]; end
            else rcnt <= rcnt - 1;
         end
         if (s_rvalid && s_rready) begin s_rvalid <= 1'b0; rbusy <= 1'b0; s_rdata <= '0; end
         if (s_awvalid && s_awready) begin waddr <= s_awaddr; aw_got <= 1'b1; end
         if (s_wvalid && s_wready) begin wd <= s_wdata; ws <= s_wstrb; w_got <= 1'b1; end
         if (aw_got && w_got && !s_bvalid) begin
            mem[waddr[9:2]] <= merge(mem[waddr[9:2]], wd, ws);
            s_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
         end
         if (s_bvalid && s_bready) s_bvalid <= 1'b0;
      end
   end

   // scoreboard queues: filled when stimulus is driven, drained by the monitor
   logic [31:0] exp_r0[$], exp_r1[$];
   logic [1:0]  exp_b[$];
   logic        exp_g[$];
   int  r0_cyc = 0, r1_cyc = 0, ar_cyc = 0, wstart_cyc = 0, m1_rv_cnt = 0;
   logic aw_ok = 1'b0, w_ok = 1'b0, wv_prev = 1'b0;

   // monitor: sample mid-cycle, compare every handshake against the queues
   always @(negedge clk) if (rst_n) begin
      if (m0_rvalid && m0_rready) begin
         if (exp_r0.size() == 0) check("r0_extra", 1, 0);
         else check("r0_data", m0_rdata, exp_r0.pop_front());
         check("r0_resp", m0_rresp, AXI_RESP_OKAY);
         check("r0_m1_rdata_quiet", m1_rdata, 0);
         r0_cyc <= cyc;
      end
      if (m1_rvalid && m1_rready) begin
         if (exp_r1.size() == 0) check("r1_extra", 1, 0);
         else check("r1_data", m1_rdata, exp_r1.pop_front());
         check("r1_resp", m1_rresp, AXI_RESP_OKAY);
         r1_cyc <= cyc;
      end
      if (s_arvalid && s_arready) begin
         if (exp_g.size() == 0) check("grant_extra", 1, 0);
         else check("grant_owner", m1_arready, exp_g.pop_front());
         ar_cyc <= cyc;
      end
      if (s_awvalid && s_awready) aw_ok <= 1'b1;
      if (s_wvalid && s_wready) w_ok <= 1'b1;
      if (m1_bvalid && m1_bready) begin
         check("b_after_aw_w", aw_ok && w_ok, 1);
         if (exp_b.size() == 0) check("b_extra", 1, 0);
         else check("b_resp", m1_bresp, exp_b.pop_front());
         aw_ok <= 1'b0; w_ok <= 1'b0;
      end
      if ((s_awvalid || s_wvalid) && !wv_prev) wstart_cyc <= cyc;
      wv_prev <= s_awvalid || s_wvalid;
      if (m1_rvalid) m1_rv_cnt <= m1_rv_cnt + 1;
   end

   task automatic rd0(input logic [31:0] a);
      int n = 0;
      bit got = 0;
      m0_araddr = a; m0_arvalid = 1'b1;
      exp_r0.push_back(ref_mem[a[9:2]]);
      while (!got && n < 300) begin
         @(negedge clk); n++;
         got = m0_arready;
      end
      check("ar0_accept", got, 1);
      @(posedge clk); #1 m0_arvalid = 1'b0;
   endtask

   task automatic rd1(input logic [31:0] a);
      int n = 0;
      bit got = 0;
      m1_araddr = a; m1_arvalid = 1'b1;
      exp_r1.push_back(ref_mem[a[9:2]]);
      while (!got && n < 300) begin
         @(negedge clk); n++;
         got = m1_arready;
      end
      check("ar1_accept", got, 1);
      @(posedge clk); #1 m1_arvalid = 1'b0;
   endtask

   task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int aw_delay);
      int n = 0;
      bit awd = 0, wdn = 0;
      m1_awaddr = a; m1_wdata = d; m1_wstrb = s; m1_wvalid = 1'b1; m1_awvalid = (aw_delay == 0);
      ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], d, s);
      exp_b.push_back(AXI_RESP_OKAY);
      while (!(awd && wdn) && n < 300) begin
         @(negedge clk);
         if (m1_awvalid && m1_awready) awd = 1;
         if (m1_wvalid && m1_wready) wdn = 1;
         @(posedge clk); #1 n++;
         if (awd) m1_awvalid = 1'b0;
         if (wdn) m1_wvalid = 1'b0;
         if (n == aw_delay && !awd) m1_awvalid = 1'b1;
      end
      check("wr_accept", awd && wdn, 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_r0.size() != 0 || exp_r1.size() != 0 || exp_b.size() != 0 || exp_g.size() != 0) && n < 500) begin
         @(posedge clk); n++;
      end
      check("drain_in_time", n < 500, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   int n, c0;
   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      @(negedge clk);
      check("rst_valids", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m0_arready,
                           m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}, 0);
      check("rst_rdata", m0_rdata | m1_rdata, 0);
      check("rst_resp", {m0_rresp, m1_rresp, m1_bresp}, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // single IFU read with one bubble before the slave sees it
      m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
      exp_r0.push_back(32'h0000_0413); exp_g.push_back(MST_IFU);
      c0 = m1_rv_cnt;
      @(negedge clk); check("ifu_bubble", s_arvalid, 0);
      @(negedge clk); check("ifu_s_arvalid", s_arvalid, 1); check("ifu_s_araddr", s_araddr, 32'h8000_0000);
      @(posedge clk); #1 m0_arvalid = 1'b0;
      drain();
      check("ifu_m1_quiet", m1_rv_cnt - c0, 0);

      // LSU read leaves priority with the IFU, then reset aborts an IFU read in RD_DATA
      exp_g.push_back(MST_LSU); rd1(32'h8000_0004); drain();
      rd_wait = 4; exp_g.push_back(MST_IFU);
      m0_araddr = 32'h8000_0008; m0_arvalid = 1'b1; n = 0;
      do begin @(negedge clk); n++; end while (!(s_rready && !s_rvalid) && n < 50);
      check("rst_reach_rd_data", s_rready, 1);
      m0_arvalid = 1'b0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("midrst_valids", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m0_arready,
                              m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}, 0);
      check("midrst_rdata", m0_rdata | m1_rdata, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; rd_wait = 1;

      // contention: reset priority favours the LSU, then strict alternation
      exp_g.push_back(1); exp_g.push_back(0); exp_g.push_back(1); exp_g.push_back(0);
      fork
         begin rd0(32'h8000_0010); rd0(32'h8000_0014); end
         begin rd1(32'h8000_0020); rd1(32'h8000_0024); end
      join
      drain();

      // LSU write with W leading AW by two cycles, then readback
      wr1(32'h8000_0100, 32'hDEAD_BEEF, 4'hF, 2);
      drain();
      exp_g.push_back(MST_LSU); rd1(32'h8000_0100); drain();
      check("ref_readback", ref_mem[8'h40], 32'hDEAD_BEEF);

      // backpressure: IFU withholds rready while the LSU waits
      m0_rready = 1'b0;
      exp_g.push_back(MST_IFU); exp_g.push_back(MST_LSU);
      rd0(32'h8000_0030);
      fork rd1(32'h8000_0034); join_none
      n = 0;
      do begin @(negedge clk); n++; end while (!s_rvalid && n < 50);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("bp_s_rready", s_rready, 0);
         check("bp_m0_rvalid", m0_rvalid, 1);
         check("bp_m1_waits", m1_arready, 0);
      end
      @(posedge clk); #1 m0_rready = 1'b1;
      drain();
      check("bp_regrant_gap", ar_cyc - r0_cyc, 2);

      // LSU read and write together: read first, write right after the IDLE bubble
      exp_g.push_back(MST_LSU);
      fork
         rd1(32'h8000_0040);
         wr1(32'h8000_0104, 32'h1122_3344, 4'b0101, 0);
      join
      drain();
      check("rw_write_gap", wstart_cyc - r1_cyc, 2);
      exp_g.push_back(MST_LSU); rd1(32'h8000_0104); drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
